// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the memory responder.
package mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_type;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_type;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with per-byte write enables and a registered read.
// Ports: clock, wen (byte lanes), index (word), wdata, rdata (one edge after index).
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic [STRB_W-1:0] wen,
    input  logic [IW-1:0]     index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and word read share the same edge; contents survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (wen[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory request responder: captures a request, waits WAIT_STATES cycles,
// then pulses mem_ready with read data or an error flag.
// Ports: reset (async, active-low), clock, mem_valid/instr/addr/wdata/wstrb
// request inputs, mem_rdata/mem_ready/mem_error registered completion outputs.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE        = 32'h0000_0000,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic              reset,
    input  logic              clock,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_error
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned AW = IW + 2;

    mem_state_type     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_type       req_q;
    mem_req_type       live_c, acc_c;
    logic              take_c, enter_resp_c, in_range_c, err_c, is_write_c;
    logic [STRB_W-1:0] wen_c;
    logic [DATA_W-1:0] arr_rdata;
    logic              ready_q, err_q, rd_ok_q;

    assign live_c = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
    assign take_c = (state_q == IDLE) && mem_valid;

    // With zero wait states the array is accessed on the capture edge, so use the live request.
    assign acc_c = (state_q == IDLE) ? live_c : req_q;

    // BASE is aligned to the window size, so the range test is a tag compare.
    assign in_range_c   = (acc_c.addr[ADDR_W-1:AW] == BASE[ADDR_W-1:AW]);
    assign is_write_c   = (acc_c.wstrb != '0);
    assign err_c        = !in_range_c ||
                          (is_write_c && ((acc_c.addr[1:0] != 2'b00) || acc_c.instr));
    assign enter_resp_c = (state_d == RESP);
    assign wen_c        = (enter_resp_c && !err_c) ? acc_c.wstrb : '0;

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request capture and completion outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_c) begin
                req_q <= live_c;
            end
            ready_q <= enter_resp_c;
            err_q   <= enter_resp_c && err_c;
            rd_ok_q <= enter_resp_c && !err_c && !is_write_c;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clock (clock),
        .wen   (wen_c),
        .index (acc_c.addr[AW-1:2]),
        .wdata (acc_c.wdata),
        .rdata (arr_rdata)
    );

    // Array output is a register; gate it with a registered qualifier so rdata is 0 outside a read response.
    assign mem_rdata = rd_ok_q ? arr_rdata : '0;
    assign mem_ready = ready_q;
    assign mem_error = err_q;

endmodule
